// File: rtl/toggle_cover_pkg.sv
// Shared types and defaults for the toggle-coverage slice.
package toggle_cover_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_ROSE = 2'd1,
    ST_FELL = 2'd2,
    ST_DONE = 2'd3
  } bit_state_t;

  localparam int unsigned DEFAULT_WIDTH = 39;

endpackage

// File: rtl/toggle_bit_fsm.sv
// Per-bit toggle tracker: records a rise and a fall, then pulses valid once.
module toggle_bit_fsm
  import toggle_cover_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic rise,
  input  logic fall,
  input  logic enable,
  input  logic clear,
  output logic valid,
  output logic complete
);

  bit_state_t state, state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_NONE;
      valid <= 1'b0;
    end else if (clear) begin
      state <= ST_NONE;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      valid <= complete;
    end
  end

  // complete flags the edge on which this bit enters DONE; it feeds the popcount
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    if (enable && !clear) begin
      unique case (state)
        ST_NONE: begin
          if (rise)      state_next = ST_ROSE;
          else if (fall) state_next = ST_FELL;
        end
        ST_ROSE: begin
          if (fall) begin
            state_next = ST_DONE;
            complete   = 1'b1;
          end
        end
        ST_FELL: begin
          if (rise) begin
            state_next = ST_DONE;
            complete   = 1'b1;
          end
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_NONE;
      endcase
    end
  end

endmodule

// File: rtl/toggle_edge_tracker.sv
// Toggle-coverage tracker: per-bit edge history, one-shot valid pulses and a covered count.
module toggle_edge_tracker
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           sig,
  input  logic                       enable,
  input  logic                       clear,
  output logic [WIDTH-1:0]           valid,
  output logic [$clog2(WIDTH+1)-1:0] covered_count,
  output logic                       all_covered
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] complete;
  logic [CW-1:0]    done_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      prev   <= sig;
      primed <= !clear;
    end
  end

  assign rise = {WIDTH{primed}} & ~prev & sig;
  assign fall = {WIDTH{primed}} & prev & ~sig;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    toggle_bit_fsm u_fsm (
      .clock    (clock),
      .reset_n  (reset_n),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .enable   (enable),
      .clear    (clear),
      .valid    (valid[g]),
      .complete (complete[g])
    );
  end

  always_comb begin
    done_inc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      done_inc = done_inc + CW'(complete[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      covered_count <= '0;
    end else if (clear) begin
      covered_count <= '0;
    end else begin
      covered_count <= covered_count + done_inc;
    end
  end

  assign all_covered = (covered_count == CW'(WIDTH));

endmodule
